// File: rtl/spread_pkg.sv
// Shared types, default sizes and width helpers for the spread tracker.
package spread_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int PRICE_W_DEF  = 8;
  localparam int CHANNELS_DEF = 4;
  localparam int DEPTH_DEF    = 8;

  // Signed spread width: one extra bit so buy - sell never overflows.
  function automatic int spread_w(input int price_w);
    return price_w + 1;
  endfunction

  // Running-sum width: DEPTH spreads accumulated without overflow.
  function automatic int sum_w(input int price_w, input int depth);
    return price_w + 1 + $clog2(depth);
  endfunction

endpackage

// File: rtl/spread_window.sv
// Per-channel statistics: last spread, min/max, and a DEPTH-deep moving sum.
module spread_window
  import spread_pkg::*;
#(
  parameter int  PRICE_W = PRICE_W_DEF,
  parameter int  DEPTH   = DEPTH_DEF,
  localparam int SW      = spread_w(PRICE_W),
  localparam int LD      = $clog2(DEPTH),
  localparam int SUM_W   = sum_w(PRICE_W, DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic signed [SW-1:0] s,
  output logic signed [SW-1:0] spread_now,
  output logic signed [SW-1:0] spread_min,
  output logic signed [SW-1:0] spread_max,
  output logic signed [SW-1:0] spread_avg,
  output logic [LD:0]          fill
);

  logic signed [SW-1:0]    buf_q [DEPTH];
  logic signed [SW-1:0]    buf_d [DEPTH];
  logic [LD-1:0]           wr_ptr_q, wr_ptr_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [LD:0]             fill_q, fill_d;
  logic signed [SW-1:0]    now_q, now_d;
  logic signed [SW-1:0]    min_q, min_d;
  logic signed [SW-1:0]    max_q, max_d;
  logic                    seen_q, seen_d;
  logic signed [SW-1:0]    old_s;

  // Next-state for the window: overwrite oldest entry, adjust sum and stats.
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    fill_d   = fill_q;
    now_d    = now_q;
    min_d    = min_q;
    max_d    = max_q;
    seen_d   = seen_q;
    old_s    = buf_q[wr_ptr_q];
    if (wr_en) begin
      buf_d[wr_ptr_q] = s;
      wr_ptr_d        = wr_ptr_q + LD'(1);
      sum_d           = sum_q + {{LD{s[SW-1]}}, s} - {{LD{old_s[SW-1]}}, old_s};
      if (fill_q != (LD+1)'(DEPTH)) fill_d = fill_q + (LD+1)'(1);
      now_d  = s;
      // The first sample seeds both extremes; the reset zeros are not data.
      if (!seen_q || (s < min_q)) min_d = s;
      if (!seen_q || (s > max_q)) max_d = s;
      seen_d = 1'b1;
    end
  end

  // Window state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wr_ptr_q <= '0;
      sum_q    <= '0;
      fill_q   <= '0;
      now_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      seen_q   <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      sum_q    <= sum_d;
      fill_q   <= fill_d;
      now_q    <= now_d;
      min_q    <= min_d;
      max_q    <= max_d;
      seen_q   <= seen_d;
    end
  end

  // Floor average: arithmetic shift keeps negative sums rounding toward -inf.
  always_comb begin
    spread_now = now_q;
    spread_min = min_q;
    spread_max = max_q;
    spread_avg = SW'(sum_q >>> LD);
    fill       = fill_q;
  end

endmodule

// File: rtl/spread_tracker.sv
// Multi-channel signed spread tracker with run/halt control and readout mux.
// Update handshake: an update is taken on a rising edge when the FSM is in RUN,
// enable_count=1, match_siganl=1, halt_signal=0 and ch_sel is a valid channel;
// upd_valid/upd_ch then pulse for exactly the following cycle. No backpressure.
module spread_tracker
  import spread_pkg::*;
#(
  parameter int  PRICE_W  = PRICE_W_DEF,
  parameter int  CHANNELS = CHANNELS_DEF,
  parameter int  DEPTH    = DEPTH_DEF,
  localparam int SW       = spread_w(PRICE_W),
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LD       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable_count,
  input  logic                 halt_signal,
  input  logic                 resume,
  input  logic                 match_siganl,
  input  logic [CH_W-1:0]      ch_sel,
  input  logic [PRICE_W-1:0]   buy_price,
  input  logic [PRICE_W-1:0]   sell_price,
  input  logic [CH_W-1:0]      rd_ch,
  output logic signed [SW-1:0] spread_now,
  output logic signed [SW-1:0] spread_min,
  output logic signed [SW-1:0] spread_max,
  output logic signed [SW-1:0] spread_avg,
  output logic [LD:0]          fill,
  output logic                 upd_valid,
  output logic [CH_W-1:0]      upd_ch,
  output logic                 halted,
  output state_e               dbg_state
);

  state_e               state_q, state_d;
  logic                 accept;
  logic                 ch_ok;
  logic signed [SW-1:0] s;
  logic [CHANNELS-1:0]  wr_en;
  logic                 upd_valid_q, upd_valid_d;
  logic [CH_W-1:0]      upd_ch_q, upd_ch_d;

  logic signed [SW-1:0] now_a [CHANNELS];
  logic signed [SW-1:0] min_a [CHANNELS];
  logic signed [SW-1:0] max_a [CHANNELS];
  logic signed [SW-1:0] avg_a [CHANNELS];
  logic [LD:0]          fill_a [CHANNELS];

  // Next-state logic: halt wins over everything, resume only leaves HALTED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (halt_signal) state_d = ST_HALTED;
                 else if (enable_count) state_d = ST_RUN;
      ST_RUN:    if (halt_signal) state_d = ST_HALTED;
                 else if (!enable_count) state_d = ST_IDLE;
      ST_HALTED: if (resume && !halt_signal) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Accept qualification and the zero-extended signed subtractor.
  always_comb begin
    ch_ok       = (32'(ch_sel) < 32'(CHANNELS));
    accept      = (state_q == ST_RUN) && enable_count && match_siganl &&
                  !halt_signal && ch_ok;
    s           = $signed({1'b0, buy_price}) - $signed({1'b0, sell_price});
    upd_valid_d = accept;
    upd_ch_d    = accept ? ch_sel : '0;
  end

  // FSM state and update-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      upd_valid_q <= upd_valid_d;
      upd_ch_q    <= upd_ch_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign wr_en[c] = accept && (ch_sel == CH_W'(c));
    spread_window #(.PRICE_W(PRICE_W), .DEPTH(DEPTH)) u_win (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en[c]),
      .s          (s),
      .spread_now (now_a[c]),
      .spread_min (min_a[c]),
      .spread_max (max_a[c]),
      .spread_avg (avg_a[c]),
      .fill       (fill_a[c])
    );
  end

  // Readout mux; out-of-range channel selects read as all zeros.
  always_comb begin
    spread_now = '0;
    spread_min = '0;
    spread_max = '0;
    spread_avg = '0;
    fill       = '0;
    if (32'(rd_ch) < 32'(CHANNELS)) begin
      spread_now = now_a[rd_ch];
      spread_min = min_a[rd_ch];
      spread_max = max_a[rd_ch];
      spread_avg = avg_a[rd_ch];
      fill       = fill_a[rd_ch];
    end
    upd_valid = upd_valid_q;
    upd_ch    = upd_ch_q;
    halted    = (state_q == ST_HALTED);
    dbg_state = state_q;
  end

endmodule

// File: doc/spread_tracker.md
# spread_tracker

Multi-channel, signed successor to the single-channel spread block. It computes `buy_price - sell_price` for one of CHANNELS instruments on each accepted match. Per channel it keeps the last spread, the running min and max, and a DEPTH-sample moving average. It sits between the order-matching logic and the display/readout path, and is gated by the same enable, match and halt controls, with halt now sticky until an explicit resume.

## Interface
Parameters:
- PRICE_W, 8, unsigned price width; spreads are PRICE_W+1 bits signed (SW).
- CHANNELS, 4, number of instruments; CH_W = max(1, clog2(CHANNELS)).
- DEPTH, 8, moving-average window; a power of two, at least 2; LD = log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable_count  in  1  level; run enable.
- halt_signal  in  1  sets sticky halt.
- resume  in  1  clears halt.
- match_siganl  in  1  update strobe for the current price pair.
- ch_sel  in  CH_W  channel being updated.
- buy_price, sell_price  in  PRICE_W  unsigned each.
- rd_ch  in  CH_W  readout channel select.
- spread_now, spread_min, spread_max, spread_avg  out  SW  signed readout of rd_ch.
- fill  out  LD+1  number of samples in rd_ch window, saturating at DEPTH.
- upd_valid  out  1  one-cycle pulse after an accepted update.
- upd_ch  out  CH_W  channel of that update.
- halted  out  1  high in HALTED.

## Operation
- FSM states IDLE, RUN, HALTED; reset enters IDLE.
- IDLE→RUN when enable_count=1. RUN→IDLE when enable_count=0.
- IDLE or RUN→HALTED when halt_signal=1.
- HALTED→IDLE when resume=1 and halt_signal=0. Halt has priority over resume.
- Update accepted iff state=RUN, enable_count=1, match_siganl=1, halt_signal=0 and ch_sel<CHANNELS. Otherwise nothing changes.
- Spread arithmetic: s = zero-extend(buy) - zero-extend(sell) in SW bits, two's complement. It never overflows; range is -(2^PRICE_W-1)..+(2^PRICE_W-1).
- On an accepted update to channel c:
  - spread_now[c] <= s.
  - First update since reset: min[c] <= s and max[c] <= s. Later updates use a signed compare.
  - The window buffer overwrites its oldest entry at wr_ptr[c], and wr_ptr wraps modulo DEPTH.
  - sum[c] <= sum[c] + s - old_entry, with sum width SW+LD.
  - fill[c] increments, saturating at DEPTH.
- spread_avg = sum >>> LD (arithmetic shift, floor toward -inf). Window entries reset to 0, so while the window is filling the average includes zeros.
- Readout is a combinational mux of channel registers by rd_ch.
- rd_ch≥CHANNELS reads all-zero outputs.

## Timing
- Reset values: every output is 0. All per-channel registers (spread_now, min, max, sum, buffers, fill, wr_ptr, seen flag) are 0. State is IDLE.
- An update sampled at edge N is visible on the readout outputs immediately after edge N.
- upd_valid and upd_ch are registered: high for exactly the cycle after edge N.
- Back-to-back updates, including to the same channel, are accepted every cycle.
- enable_count rising at edge N gives RUN after N. The first accepted update is at edge N+1.
- halt_signal and match_siganl together in the same cycle: no update.
- halted asserts after that edge.
- reset_n asserted mid-operation: all state clears immediately (asynchronous). Deassertion is synchronised externally.

## Structure
- Package spread_pkg holds:
  - the state enum (ST_IDLE, ST_RUN, ST_HALTED);
  - default PRICE_W/CHANNELS/DEPTH localparams;
  - an SW/sum-width helper function.
- Sub-module spread_window is instantiated CHANNELS times. It contains the DEPTH×SW circular buffer, wr_ptr, running sum, fill, min, max, seen flag and last spread. Its ports are wr_en, s, and the stat outputs.
- The top level contains the FSM, the accept logic, the subtractor, the readout mux and the upd_* registers.

## Test plan
- Reset, then read every channel with no updates → all outputs 0, halted=0, upd_valid never high.
- enable_count=0, match_siganl=1, buy=80, sell=70, ch 0, 3 cycles → spread_now stays 0, fill=0.
- RUN; ch1 updated with (82,78) then (70,65) then (60,72) → spread_now=-12, min=-12, max=5, fill=3, avg=(4+5-12)>>>3=-1. Each update gives a 1-cycle upd_valid with upd_ch=1.
- Ten updates of ch2 with spreads 1..10, DEPTH=8 → fill=8, sum=52, avg=6, wr_ptr wrapped to 2. Ch0, ch1 and ch3 are unchanged.
- halt_signal pulse, then updates (90,10) → no change, halted=1. Resume plus halt in the same cycle → stays HALTED. Resume alone → IDLE. Enable plus update (81,55) → spread_now=26.
- Edge values: buy=255, sell=0 → +255; buy=0, sell=255 → -255; min/max are correct and there is no wrap. reset_n pulsed between updates → everything returns to 0 asynchronously.
